// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : EX-stage exception/eret sequencer: issue strobe, pipeline flush,
//            fetch redirect. Interrupt support enabled by macro EXC_CTRL_INT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        stall,
    input  logic        syscall,
    input  logic        brk,
    input  logic        teq_true,
    input  logic        eret_req,
    input  logic [5:0]  int_req,
    input  logic [31:0] status,
    input  logic [31:0] epc_in,
    output logic        exception,
    output logic        eret,
    output logic [31:0] cause,
    output logic [31:0] exc_pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] C_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [4:0] C_CODE_INT   = 5'd0;
    localparam logic [4:0] C_CODE_SYS   = 5'd8;
    localparam logic [4:0] C_CODE_BRK   = 5'd9;
    localparam logic [4:0] C_CODE_TRAP  = 5'd13;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        evt_eret_q, evt_eret_d;
    logic        evt_int_q, evt_int_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exception_q, exception_d;
    logic        eret_q, eret_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [5:0]  w_pend;
    logic        w_int_ok;
    logic        w_open;
    logic        w_accept;
    logic        w_sel_eret;
    logic        w_sel_int;
    logic [4:0]  w_code;
    logic        w_unused;

`ifdef EXC_CTRL_INT_EN
    logic [5:0] int_pend_q, int_pend_d;

    // A line asserted on the clearing edge must survive the clear.
    always_comb begin
        int_pend_d = int_pend_q | int_req;
        if (state_q == S_ISSUE && evt_int_q) begin
            int_pend_d = int_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_pend_q <= 6'd0;
        end else begin
            int_pend_q <= int_pend_d;
        end
    end

    assign w_pend   = int_pend_q;
    assign w_int_ok = status[0] & status[4] & (|int_pend_q);
    assign w_unused = ^status[31:5];
`else
    assign w_pend   = 6'd0;
    assign w_int_ok = 1'b0;
    assign w_unused = ^{status[31:5], status[4], status[0], int_req};
`endif

    always_comb begin
        w_open     = (state_q == S_IDLE) && !stall && inst_valid;
        w_accept   = 1'b0;
        w_sel_eret = 1'b0;
        w_sel_int  = 1'b0;
        w_code     = C_CODE_INT;
        if (syscall && status[1]) begin
            w_accept = w_open;
            w_code   = C_CODE_SYS;
        end else if (brk && status[2]) begin
            w_accept = w_open;
            w_code   = C_CODE_BRK;
        end else if (teq_true && status[3]) begin
            w_accept = w_open;
            w_code   = C_CODE_TRAP;
        end else if (eret_req) begin
            w_accept   = w_open;
            w_sel_eret = 1'b1;
        end else if (w_int_ok) begin
            w_accept  = w_open;
            w_sel_int = 1'b1;
        end
    end

    // Outputs are registered: each *_d reflects the state being entered.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        evt_eret_d       = evt_eret_q;
        evt_int_d        = evt_int_q;
        cause_d          = cause_q;
        exc_pc_d         = exc_pc_q;
        exception_d      = 1'b0;
        eret_d           = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d     = S_ISSUE;
                    evt_eret_d  = w_sel_eret;
                    evt_int_d   = w_sel_int;
                    cause_d     = {16'd0, w_pend, 3'd0, w_code, 2'd0};
                    exc_pc_d    = inst_pc;
                    exception_d = !w_sel_eret;
                    eret_d      = w_sel_eret;
                    flush_d     = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_FLUSH;
                cnt_d   = C_FLUSH_LAST;
                flush_d = 1'b1;
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d          = S_REDIRECT;
                    redirect_valid_d = 1'b1;
                    if (!evt_eret_q) begin
                        redirect_pc_d = HANDLER_ADDR;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            S_REDIRECT: begin
                state_d = S_IDLE;
                if (evt_eret_q) begin
                    redirect_pc_d = epc_in;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            evt_eret_q       <= 1'b0;
            evt_int_q        <= 1'b0;
            cause_q          <= 32'd0;
            exc_pc_q         <= 32'd0;
            exception_q      <= 1'b0;
            eret_q           <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            evt_eret_q       <= evt_eret_d;
            evt_int_q        <= evt_int_d;
            cause_q          <= cause_d;
            exc_pc_q         <= exc_pc_d;
            exception_q      <= exception_d;
            eret_q           <= eret_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // The eret target is the live EPC during the redirect cycle.
    assign redirect_pc    = (state_q == S_REDIRECT && evt_eret_q) ? epc_in : redirect_pc_q;
    assign exception      = exception_q;
    assign eret           = eret_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign cause          = cause_q;
    assign exc_pc         = exc_pc_q;

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0040_0004: exception handler entry PC.
REQ-002 Parameter FLUSH_CYCLES, default 3: flush length in cycles; legal range 1..15.
REQ-003 clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 rst  in  1: reset, asynchronous assertion, active-low.
REQ-005 inst_valid  in  1: the EX-stage instruction is valid.
REQ-006 inst_pc  in  32: PC of the EX-stage instruction.
REQ-007 stall  in  1: pipeline stall; no new event is accepted while this is high.
REQ-008 syscall, brk, teq_true, eret_req  in  1 each: decoded EX-stage event requests.
REQ-009 int_req  in  6: external interrupt lines, level-sensitive.
REQ-010 status  in  32: CP0 Status; bit0 global IE, bit1 syscall enable, bit2 break enable, bit3 trap enable, bit4 interrupt enable.
REQ-011 epc_in  in  32: CP0 EPC value.
REQ-012 exception  out  1: one-cycle CP0 exception write strobe.
REQ-013 eret  out  1: one-cycle CP0 eret strobe.
REQ-014 cause  out  32: CP0 Cause write value; bits[6:2] ExcCode, bits[15:10] pending interrupt lines, all other bits 0.
REQ-015 exc_pc  out  32: EPC write value sent to CP0.
REQ-016 flush  out  1: kills IF/ID/EX.
REQ-017 redirect_valid  out  1 and redirect_pc  out  32: one-cycle fetch redirect and its target.

Function
REQ-018 FSM states: IDLE, ISSUE, FLUSH, REDIRECT.
REQ-019 In IDLE with stall=0 and inst_valid=1, an event is accepted if it is enabled, using fixed priority: syscall (status[1], code 8) > brk (status[2], code 9) > teq_true (status[3], code 13) > eret_req (no enable required) > interrupt (status[0]&status[4]&|int_pend, code 0).
REQ-020 On acceptance, the FSM latches the event type, inst_pc and cause, then moves to ISSUE.
REQ-021 In ISSUE, exactly one of exception or eret is high for exactly 1 cycle, with cause and exc_pc valid in that cycle; next state is FLUSH.
REQ-022 In FLUSH, flush is high for exactly FLUSH_CYCLES consecutive cycles, counted by a 4-bit down-counter; next state is REDIRECT.
REQ-023 flush is also high during the ISSUE cycle.
REQ-024 In REDIRECT, redirect_valid is high for 1 cycle; then the FSM returns to IDLE.
REQ-025 redirect_pc = HANDLER_ADDR for exceptions and interrupts.
REQ-026 For eret, redirect_pc = epc_in sampled in the REDIRECT cycle.
REQ-027 Acceptance-to-redirect latency is FLUSH_CYCLES+2 cycles.
REQ-028 Disabled requests, and requests arriving outside IDLE or while stall=1, are dropped (synchronous requests) or stay pending (interrupts).
REQ-029 int_pend[5:0] is a sticky register: set on each int_req line that is high; cleared to 0 at the ISSUE cycle of an interrupt only.
REQ-030 int_req set and clear on the same edge: set wins.
REQ-031 cause[15:10] reflects int_pend for every event type.
REQ-032 When no strobe is active, cause and exc_pc hold their last latched value.

Reset
REQ-033 While rst=0: FSM is in IDLE; counter, int_pend, cause and exc_pc are 0; exception, eret, flush and redirect_valid are 0; redirect_pc is 0.
REQ-034 Reset asserted mid-sequence aborts the sequence immediately, with no strobe or redirect emitted.
REQ-035 The first acceptance after reset release is possible on the first clock edge.

Configuration
REQ-036 Macro EXC_CTRL_INT_EN defined: interrupt logic is present as specified.
REQ-037 Macro EXC_CTRL_INT_EN undefined: int_req is ignored, int_pend is absent, cause[15:10]=0, and the interrupt event is never accepted.

Verification
REQ-038 status=32'h1F, syscall=1, inst_pc=32'h0040_0100 -> next cycle exception=1, cause=32'h20, exc_pc=32'h0040_0100; flush high 4 cycles; redirect_pc=32'h0040_0004 at cycle 5.
REQ-039 syscall=1 and brk=1 together, status=32'h1F -> cause ExcCode 8 only; the brk request is dropped.
REQ-040 eret_req=1, epc_in=32'h0040_0200 -> eret pulse, exception=0, redirect_pc=32'h0040_0200.
REQ-041 int_req=6'b000100 for 1 cycle with status=32'h0E, then status=32'h1F -> interrupt taken, cause=32'h0000_1000, int_pend cleared.
REQ-042 rst=0 during FLUSH -> flush=0 immediately, no redirect_valid; sequence restarts cleanly after release.
REQ-043 brk=1 with status[2]=0, or with stall=1 -> no outputs change; FSM stays in IDLE.
